// File: rtl/apb_master.sv
//==============================================================================
// Module   : apb_master
// Summary  : Turns a valid/ready command into an APB4 transfer with a wait-state timeout.
// Revision : 1.0
//==============================================================================
`default_nettype none

module apb_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int c_strb_w = DATA_WIDTH / 8;
    // A zero limit still needs a 1-bit counter so the declarations stay legal.
    localparam int c_cnt_w  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit c_timeout_en = (TIMEOUT_CYCLES != 0);
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_wait_cnt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;

    logic                  w_psel_nxt;
    logic                  w_penable_nxt;
    logic                  w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [DATA_WIDTH-1:0] w_pwdata_nxt;
    logic [c_strb_w-1:0]   w_pstrb_nxt;
    logic [2:0]            w_pprot_nxt;
    logic                  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
    logic                  w_rsp_err_nxt;
    logic                  w_rsp_timeout_nxt;

    assign cmd_ready = (r_state == ST_IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            PPROT       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_cnt_nxt;
            PSEL        <= w_psel_nxt;
            PENABLE     <= w_penable_nxt;
            PWRITE      <= w_pwrite_nxt;
            PADDR       <= w_paddr_nxt;
            PWDATA      <= w_pwdata_nxt;
            PSTRB       <= w_pstrb_nxt;
            PPROT       <= w_pprot_nxt;
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_rdata   <= w_rsp_rdata_nxt;
            rsp_err     <= w_rsp_err_nxt;
            rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_wait_cnt;
        w_pwrite_nxt      = PWRITE;
        w_paddr_nxt       = PADDR;
        w_pwdata_nxt      = PWDATA;
        w_pstrb_nxt       = PSTRB;
        w_pprot_nxt       = PPROT;
        w_rsp_valid_nxt   = 1'b0;
        w_rsp_rdata_nxt   = rsp_rdata;
        w_rsp_err_nxt     = rsp_err;
        w_rsp_timeout_nxt = rsp_timeout;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_pwrite_nxt = cmd_write;
                    w_paddr_nxt  = cmd_addr;
                    w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
                    w_pstrb_nxt  = cmd_write ? cmd_strb : '0;
                    w_pprot_nxt  = cmd_prot;
                    w_state_nxt  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = PSLVERR;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = PWRITE ? '0 : PRDATA;
                    w_state_nxt       = ST_IDLE;
                end else if (c_timeout_en && (r_wait_cnt == c_cnt_last)) begin
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = ST_IDLE;
                end else if (r_wait_cnt != c_cnt_max) begin
                    w_cnt_nxt = r_wait_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Bus select/enable are registered copies of the phase being entered.
        w_psel_nxt    = (w_state_nxt != ST_IDLE);
        w_penable_nxt = (w_state_nxt == ST_ACCESS);
    end

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
//==============================================================================
// Module   : tb_apb_master
// Summary  : Self-checking bench for apb_master against a transfer-level model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_apb_master;

    localparam int TO = 16;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    // One transfer: the expected shape is derived from the wait count alone.
    task automatic do_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [2:0] prot, input int waits,
                           input logic slverr, input logic [31:0] rdata, input string name);
        logic        to;
        int          acc_len, total, psel_n, pen_n, rsp_n, bad_stab, bad_ready, acc_seen;
        logic [31:0] exp_wdata, exp_rdata;
        logic [3:0]  exp_strb;
        logic        exp_err;
        to        = (waits >= TO);
        acc_len   = to ? TO : waits + 1;
        total     = acc_len + 2;
        exp_wdata = wr ? wdata : 32'h0;
        exp_strb  = wr ? strb : 4'h0;
        exp_rdata = (wr || to) ? 32'h0 : rdata;
        exp_err   = to || slverr;
        psel_n = 0; pen_n = 0; rsp_n = 0; bad_stab = 0; bad_ready = 0; acc_seen = 0;

        @(negedge PCLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready got %b want 1", name, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;

        for (int c = 1; c <= total; c++) begin
            @(negedge PCLK);
            if (c == 1) begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdata = $urandom;
                cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
            end
            psel_n += int'(PSEL);
            pen_n  += int'(PENABLE);
            rsp_n  += int'(rsp_valid);
            if (c < total && cmd_ready !== 1'b0) bad_ready++;
            if (PADDR !== addr || PWRITE !== wr || PWDATA !== exp_wdata ||
                PSTRB !== exp_strb || PPROT !== prot) bad_stab++;
            if (PSEL && PENABLE) begin
                PREADY  = (acc_seen == waits);
                PSLVERR = (acc_seen == waits) ? slverr : 1'b1;
                PRDATA  = (acc_seen == waits) ? rdata : $urandom;
                acc_seen++;
            end else begin
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
        end

        checks++;
        if (rsp_valid !== 1'b1 || PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s rsp_cycle got valid=%b psel=%b pen=%b ready=%b want 1 0 0 1",
                     name, rsp_valid, PSEL, PENABLE, cmd_ready);
        end
        checks++;
        if (rsp_rdata !== exp_rdata) begin
            errors++;
            $display("FAIL %s rsp_rdata got %h want %h", name, rsp_rdata, exp_rdata);
        end
        checks++;
        if (rsp_err !== exp_err || rsp_timeout !== to) begin
            errors++;
            $display("FAIL %s rsp_flags got err=%b to=%b want err=%b to=%b",
                     name, rsp_err, rsp_timeout, exp_err, to);
        end
        checks++;
        if (psel_n != acc_len + 1 || pen_n != acc_len) begin
            errors++;
            $display("FAIL %s phase_len got psel=%0d pen=%0d want psel=%0d pen=%0d",
                     name, psel_n, pen_n, acc_len + 1, acc_len);
        end
        checks++;
        if (rsp_n != 1) begin
            errors++;
            $display("FAIL %s rsp_pulses got %0d want 1", name, rsp_n);
        end
        checks++;
        if (bad_stab != 0 || bad_ready != 0) begin
            errors++;
            $display("FAIL %s bus_stability got stab_err=%0d ready_err=%0d want 0 0",
                     name, bad_stab, bad_ready);
        end

        @(negedge PCLK);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== exp_rdata || rsp_err !== exp_err ||
            rsp_timeout !== to) begin
            errors++;
            $display("FAIL %s rsp_hold got valid=%b rdata=%h err=%b to=%b want 0 %h %b %b",
                     name, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, to);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || PWRITE !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ctrl got psel=%b pen=%b pwrite=%b ready=%b want 0 0 0 1",
                     name, PSEL, PENABLE, PWRITE, cmd_ready);
        end
        checks++;
        if (PADDR !== 16'h0 || PWDATA !== 32'h0 || PSTRB !== 4'h0 || PPROT !== 3'h0) begin
            errors++;
            $display("FAIL %s bus got addr=%h wdata=%h strb=%h prot=%h want all 0",
                     name, PADDR, PWDATA, PSTRB, PPROT);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp got valid=%b rdata=%h err=%b to=%b want all 0",
                     name, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        check_reset_values("reset");
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_reset_values("reset_release");
    endtask

    task automatic test_zero_wait_write();
        do_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, "zero_wait_write");
    endtask

    task automatic test_read_waits();
        do_xfer(1'b0, 16'h0124, 32'h12345678, 4'hA, 3'b010, 3, 1'b0, 32'hCAFEF00D, "read_3_waits");
    endtask

    task automatic test_slave_error();
        do_xfer(1'b1, 16'h0200, 32'h0BADF00D, 4'h3, 3'b001, 2, 1'b1, 32'h0, "slverr_write");
        do_xfer(1'b0, 16'h0204, 32'h0, 4'h0, 3'b100, 2, 1'b0, 32'h55AA33CC, "slverr_ignored_in_wait");
    endtask

    task automatic test_timeout();
        do_xfer(1'b0, 16'h0300, 32'h0, 4'h0, 3'b111, 1000, 1'b0, 32'h11112222, "timeout_stuck");
        do_xfer(1'b0, 16'h0304, 32'h0, 4'h0, 3'b011, TO - 1, 1'b0, 32'h33334444, "ready_last_cycle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, TO + 2)), 1'($urandom), $urandom, "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ready_obs, psel_obs, pen_obs, rsp_obs;
        logic [15:0] addr_b, addr_at4;
        logic [31:0] rd_b, rdata_at3, rdata_at6;
        int          acc_cnt;
        int          acc_at [2];
        logic        switch_pending;
        addr_b = 16'($urandom) | 16'h8000;
        rd_b   = $urandom;
        ready_obs = '0; psel_obs = '0; pen_obs = '0; rsp_obs = '0;
        acc_cnt = 0; acc_at[0] = -1; acc_at[1] = -1; switch_pending = 1'b0;
        addr_at4 = '0; rdata_at3 = '0; rdata_at6 = '0;

        @(negedge PCLK);
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = rd_b;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040;
        cmd_wdata = 32'hA5A5A5A5; cmd_strb = 4'hF; cmd_prot = 3'b000;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge PCLK);
            if (switch_pending) begin
                switch_pending = 1'b0;
                if (acc_cnt == 1) begin
                    cmd_write = 1'b0; cmd_addr = addr_b; cmd_wdata = $urandom;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            ready_obs[c] = cmd_ready;
            psel_obs[c]  = PSEL;
            pen_obs[c]   = PENABLE;
            rsp_obs[c]   = rsp_valid;
            if (c == 3) rdata_at3 = rsp_rdata;
            if (c == 4) addr_at4 = PADDR;
            if (c == 6) rdata_at6 = rsp_rdata;
            if (cmd_ready && cmd_valid && acc_cnt < 2) begin
                acc_at[acc_cnt] = c;
                acc_cnt++;
                switch_pending = 1'b1;
            end
        end
        cmd_valid = 1'b0;

        checks++;
        if (acc_at[0] != 0 || acc_at[1] != 3) begin
            errors++;
            $display("FAIL b2b accept_cycles got %0d,%0d want 0,3", acc_at[0], acc_at[1]);
        end
        checks++;
        if (ready_obs !== 7'b1001001) begin
            errors++;
            $display("FAIL b2b cmd_ready got %b want 1001001", ready_obs);
        end
        checks++;
        if (psel_obs !== 7'b0110110 || pen_obs !== 7'b0100100) begin
            errors++;
            $display("FAIL b2b psel_penable got %b %b want 0110110 0100100", psel_obs, pen_obs);
        end
        checks++;
        if (rsp_obs !== 7'b1001000) begin
            errors++;
            $display("FAIL b2b rsp_valid got %b want 1001000", rsp_obs);
        end
        checks++;
        if (addr_at4 !== addr_b || rdata_at3 !== 32'h0 || rdata_at6 !== rd_b) begin
            errors++;
            $display("FAIL b2b data got addr=%h rd3=%h rd6=%h want %h 0 %h",
                     addr_at4, rdata_at3, rdata_at6, addr_b, rd_b);
        end
        @(negedge PCLK);
    endtask

    task automatic test_reset_mid_access();
        int rsp_seen;
        rsp_seen = 0;
        @(negedge PCLK);
        PREADY = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0ABC;
        cmd_wdata = 32'h13572468; cmd_strb = 4'h5; cmd_prot = 3'b101;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        repeat (3) @(negedge PCLK);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid in_access got psel=%b pen=%b want 1 1", PSEL, PENABLE);
        end
        #2 PRESETn = 1'b0;
        #1;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async_drop got psel=%b pen=%b want 0 0", PSEL, PENABLE);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            rsp_seen += int'(rsp_valid);
        end
        PRESETn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge PCLK);
            rsp_seen += int'(rsp_valid);
        end
        checks++;
        if (rsp_seen != 0) begin
            errors++;
            $display("FAIL rst_mid rsp_pulses got %0d want 0", rsp_seen);
        end
        check_reset_values("rst_mid_after");
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_zero_wait_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
